branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: 2-bit saturating-counter BHT for conditional
// branches plus a direct-mapped BTB for unconditional control transfers.
module branch_predictor #(
    parameter int unsigned BHT_ENTRIES = 32,
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        cond_branch,
    input  logic        uncond_branch,
    input  logic        jump,
    input  logic        link,
    input  logic [6:0]  branch_imm1,
    input  logic [4:0]  branch_imm2,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_cond,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        pred_taken,
    output logic [31:0] pred_pc
);

    localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W     = 30 - BTB_IDX_W;

    logic [BHT_ENTRIES-1:0][1:0] bht;
    logic [BTB_ENTRIES-1:0]      btb_valid;
    logic [TAG_W-1:0]            btb_tag    [BTB_ENTRIES];
    logic [31:0]                 btb_target [BTB_ENTRIES];

    logic [BHT_IDX_W-1:0] if_bht_idx;
    logic [BHT_IDX_W-1:0] upd_bht_idx;
    logic [BTB_IDX_W-1:0] if_btb_idx;
    logic [BTB_IDX_W-1:0] upd_btb_idx;
    logic [TAG_W-1:0]     if_tag;
    logic [TAG_W-1:0]     upd_tag;

    assign if_bht_idx  = if_pc[2 +: BHT_IDX_W];
    assign upd_bht_idx = upd_pc[2 +: BHT_IDX_W];
    assign if_btb_idx  = if_pc[2 +: BTB_IDX_W];
    assign upd_btb_idx = upd_pc[2 +: BTB_IDX_W];
    assign if_tag      = if_pc[31 -: TAG_W];
    assign upd_tag     = upd_pc[31 -: TAG_W];

    // Classification hints and the byte offset of the PCs carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{jump, link, if_pc[1:0], upd_pc[1:0]};

    // ---------------- prediction (combinational) ----------------
    logic [31:0] b_imm;
    logic [31:0] seq_pc;
    logic [31:0] br_target;
    logic        btb_hit;
    logic [31:0] target;

    assign b_imm     = {{19{branch_imm1[6]}}, branch_imm1[6], branch_imm2[0],
                        branch_imm1[5:0], branch_imm2[4:1], 1'b0};
    assign seq_pc    = if_pc + 32'd4;
    assign br_target = if_pc + b_imm;
    assign btb_hit   = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);

    always_comb begin
        pred_taken = 1'b0;
        target     = seq_pc;
        if (!reset && if_valid) begin
            if (cond_branch) begin
                pred_taken = bht[if_bht_idx][1];
                target     = br_target;
            end else if (uncond_branch) begin
                pred_taken = btb_hit;
                target     = btb_target[if_btb_idx];
            end
        end
        pred_pc = pred_taken ? target : seq_pc;
    end

    // ---------------- training ----------------
    logic [1:0] upd_ctr;
    logic [1:0] ctr_next;

    always_comb begin
        upd_ctr  = bht[upd_bht_idx];
        ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != 2'b11) ctr_next = upd_ctr + 2'b01;
        end else begin
            if (upd_ctr != 2'b00) ctr_next = upd_ctr - 2'b01;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bht       <= {BHT_ENTRIES{2'b01}};
            btb_valid <= '0;
        end else if (upd_valid) begin
            if (upd_cond)  bht[upd_bht_idx]       <= ctr_next;
            if (upd_taken) btb_valid[upd_btb_idx] <= 1'b1;
        end
    end

    // Tag/target payload needs no reset; the valid bits gate it.
    always_ff @(posedge clock) begin
        if (!reset && upd_valid && upd_taken) begin
            btb_tag[upd_btb_idx]    <= upd_tag;
            btb_target[upd_btb_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        cond_branch;
    logic        uncond_branch;
    logic        jump;
    logic        link;
    logic [6:0]  branch_imm1;
    logic [4:0]  branch_imm2;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_cond;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        pred_taken;
    logic [31:0] pred_pc;

    int vectors    = 0;
    int miscompares = 0;

    branch_predictor #(.BHT_ENTRIES(32), .BTB_ENTRIES(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .cond_branch   (cond_branch),
        .uncond_branch (uncond_branch),
        .jump          (jump),
        .link          (link),
        .branch_imm1   (branch_imm1),
        .branch_imm2   (branch_imm2),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_cond      (upd_cond),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc)
    );

    always #5 clock = ~clock;

    task automatic check_pred(input string tag, input logic exp_taken, input logic [31:0] exp_pc);
        vectors++;
        assert (pred_taken === exp_taken) else begin
            miscompares++;
            $error("FAIL %s pred_taken observed=%0b expected=%0b", tag, pred_taken, exp_taken);
        end
        vectors++;
        assert (pred_pc === exp_pc) else begin
            miscompares++;
            $error("FAIL %s pred_pc observed=%08h expected=%08h", tag, pred_pc, exp_pc);
        end
    endtask

    task automatic fetch(input logic v, input logic c, input logic u, input logic [31:0] pc,
                         input logic [6:0] i1, input logic [4:0] i2);
        if_valid      = v;
        cond_branch   = c;
        uncond_branch = u;
        jump          = u;
        link          = 1'b0;
        if_pc         = pc;
        branch_imm1   = i1;
        branch_imm2   = i2;
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic c, input logic t, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_cond   = c;
        upd_taken  = t;
        upd_target = tgt;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        upd_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_cond  = 1'b0;
        upd_taken = 1'b0;
        upd_target = '0;
        fetch(1'b1, 1'b1, 1'b0, 32'h100, 7'h00, 5'h10);
        set_upd(32'h100, 1'b1, 1'b1, 32'h110);
        #1;
        check_pred("reset_cond", 1'b0, 32'h104);
        tick();
        reset = 1'b0;
        fetch(1'b1, 1'b1, 1'b0, 32'h100, 7'h00, 5'h10);
        check_pred("req033", 1'b0, 32'h104);
        fetch(1'b1, 1'b0, 1'b1, 32'h100, 7'h00, 5'h10);
        check_pred("btb_empty", 1'b0, 32'h104);

        set_upd(32'h100, 1'b1, 1'b1, 32'h110);
        tick();
        fetch(1'b1, 1'b1, 1'b0, 32'h100, 7'h00, 5'h10);
        check_pred("req034", 1'b1, 32'h110);

        for (int i = 0; i < 5; i++) begin
            set_upd(32'h100, 1'b1, 1'b1, 32'h110);
            tick();
        end
        check_pred("sat_hi", 1'b1, 32'h110);
        fetch(1'b1, 1'b1, 1'b0, 32'h104, 7'h00, 5'h10);
        check_pred("other_idx", 1'b0, 32'h108);
        fetch(1'b0, 1'b1, 1'b0, 32'h100, 7'h00, 5'h10);
        check_pred("no_valid", 1'b0, 32'h104);

        fetch(1'b1, 1'b1, 1'b0, 32'h100, 7'h00, 5'h10);
        set_upd(32'h100, 1'b1, 1'b0, 32'h0);
        tick();
        check_pred("ctr2", 1'b1, 32'h110);
        set_upd(32'h100, 1'b1, 1'b0, 32'h0);
        tick();
        check_pred("ctr1", 1'b0, 32'h104);
        set_upd(32'h100, 1'b1, 1'b0, 32'h0);
        tick();
        check_pred("ctr0", 1'b0, 32'h104);
        set_upd(32'h100, 1'b1, 1'b1, 32'h110);
        tick();
        check_pred("ctr0_plus1", 1'b0, 32'h104);

        fetch(1'b1, 1'b1, 1'b1, 32'h100, 7'h00, 5'h10);
        check_pred("prio_cond", 1'b0, 32'h104);
        fetch(1'b1, 1'b0, 1'b1, 32'h100, 7'h00, 5'h10);
        check_pred("btb_hit_100", 1'b1, 32'h110);

        fetch(1'b1, 1'b1, 1'b0, 32'h0, 7'h7F, 5'h1F);
        check_pred("back_pre", 1'b0, 32'h4);
        set_upd(32'h0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        tick();
        check_pred("back_wrap", 1'b1, 32'hFFFF_FFFE);
        fetch(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 7'h00, 5'h00);
        check_pred("seq_wrap", 1'b0, 32'h0);

        set_upd(32'h2000, 1'b0, 1'b1, 32'h3000);
        tick();
        fetch(1'b1, 1'b0, 1'b1, 32'h2000, 7'h00, 5'h00);
        check_pred("btb_2000", 1'b1, 32'h3000);
        fetch(1'b1, 1'b0, 1'b1, 32'h4000, 7'h00, 5'h00);
        check_pred("btb_tag_miss", 1'b0, 32'h4004);
        fetch(1'b1, 1'b0, 1'b1, 32'h0, 7'h00, 5'h00);
        check_pred("btb_evict", 1'b0, 32'h4);
        fetch(1'b1, 1'b1, 1'b0, 32'h0, 7'h7F, 5'h1F);
        check_pred("bht_nocond", 1'b1, 32'hFFFF_FFFE);

        set_upd(32'h2000, 1'b0, 1'b0, 32'h7777);
        tick();
        check_pred("bht_keep", 1'b1, 32'hFFFF_FFFE);
        fetch(1'b1, 1'b0, 1'b1, 32'h2000, 7'h00, 5'h00);
        check_pred("btb_keep", 1'b1, 32'h3000);

        fetch(1'b1, 1'b1, 1'b0, 32'h100, 7'h00, 5'h10);
        set_upd(32'h100, 1'b1, 1'b0, 32'h0);
        #1;
        check_pred("same_cyc_old", 1'b1, 32'h110);
        tick();
        check_pred("same_cyc_new", 1'b0, 32'h104);

        fetch(1'b1, 1'b0, 1'b1, 32'h4000, 7'h00, 5'h00);
        set_upd(32'h4000, 1'b0, 1'b1, 32'h5000);
        #1;
        check_pred("btb_same_old", 1'b0, 32'h4004);
        tick();
        check_pred("btb_same_new", 1'b1, 32'h5000);

        fetch(1'b1, 1'b1, 1'b0, 32'h100, 7'h00, 5'h10);
        set_upd(32'h100, 1'b1, 1'b1, 32'h110);
        tick();
        check_pred("pre_reset", 1'b1, 32'h110);
        reset = 1'b1;
        #1;
        check_pred("reset_gate_cond", 1'b0, 32'h104);
        fetch(1'b1, 1'b0, 1'b1, 32'h4000, 7'h00, 5'h00);
        check_pred("reset_gate_btb", 1'b0, 32'h4004);
        tick();
        reset = 1'b0;
        #1;
        check_pred("post_reset_btb", 1'b0, 32'h4004);
        fetch(1'b1, 1'b1, 1'b0, 32'h100, 7'h00, 5'h10);
        check_pred("post_reset_cond", 1'b0, 32'h104);
        set_upd(32'h100, 1'b1, 1'b1, 32'h110);
        tick();
        check_pred("post_reset_w1", 1'b1, 32'h110);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
